dl_multi_capture: RTL and testbench

- Parametrised successor to the single 32-bit parallel-port input of the datalogger SoC.
- Samples CH_NUM external channels of DATA_W bits at a programmable rate, with start/stop/trigger control, and buffers frames in a FIFO.
- Frames leave through a valid/ready stream toward the HPS-side bridge.
- Overflow is counted rather than silently lost.

---
 rtl/dl_multi_capture.sv | 202 ++++++++++++++++++++
 tb/tb_dl_multi_capture.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_multi_capture.sv
// Multi-channel sampled capture with start/stop/trigger control and an overflow-counting frame FIFO.
// Define DL_TIMESTAMP_EN to store a free-running 32-bit cycle timestamp alongside every frame.
module dl_multi_capture #(
    parameter int CH_NUM     = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int CNT_W      = 16
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic [CH_NUM*DATA_W-1:0]    ch_data_in,
    input  logic                        trig_in,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        trig_en,
    input  logic [DIV_W-1:0]            sample_div,
    input  logic [CNT_W-1:0]            frame_limit,
    input  logic                        clr_ovf,
    output logic [CH_NUM*DATA_W-1:0]    out_data,
`ifdef DL_TIMESTAMP_EN
    output logic [31:0]                 out_timestamp,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        ovf_flag,
    output logic [CNT_W-1:0]            ovf_cnt
);

    localparam int FRAME_W = CH_NUM * DATA_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
`ifdef DL_TIMESTAMP_EN
    localparam int ENTRY_W = FRAME_W + 32;
`else
    localparam int ENTRY_W = FRAME_W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN
    } state_t;

    logic [FRAME_W-1:0] ch_s1, ch_s2;
    logic               trig_s1, trig_s2, trig_d;
    logic               trig_edge;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            ch_s1   <= '0;
            ch_s2   <= '0;
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_d  <= 1'b0;
        end else begin
            ch_s1   <= ch_data_in;
            ch_s2   <= ch_s1;
            trig_s1 <= trig_in;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;
        end
    end

    assign trig_edge = trig_s2 & ~trig_d;

    state_t             state_q, state_n;
    logic [DIV_W-1:0]   div_q;
    logic [CNT_W-1:0]   frame_cnt_q;
    logic [CNT_W-1:0]   frame_cnt_inc;
    logic               tick;

    assign frame_cnt_inc = frame_cnt_q + CNT_W'(1);

    // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
    always_comb begin
        state_n = state_q;
        tick    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) state_n = ST_ARMED;
            end
            ST_ARMED: begin
                if (stop)                        state_n = ST_IDLE;
                else if (!trig_en || trig_edge)  state_n = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else begin
                    tick = (div_q == sample_div);
                    if (tick && frame_limit != '0 && frame_cnt_inc == frame_limit)
                        state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) state_q <= ST_IDLE;
        else             state_q <= state_n;
    end

    assign busy = (state_q != ST_IDLE);

    // The divider is preloaded to sample_div on RUN entry so the first RUN cycle already ticks.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            div_q       <= '0;
            frame_cnt_q <= '0;
        end else if (state_q == ST_IDLE && state_n == ST_ARMED) begin
            div_q       <= '0;
            frame_cnt_q <= '0;
        end else if (state_q == ST_ARMED && state_n == ST_RUN) begin
            div_q       <= sample_div;
        end else if (tick) begin
            div_q       <= '0;
            frame_cnt_q <= frame_cnt_inc;
        end else if (state_q == ST_RUN && !stop) begin
            div_q       <= div_q + DIV_W'(1);
        end
    end

    logic [ENTRY_W-1:0] push_entry;

`ifdef DL_TIMESTAMP_EN
    logic [31:0] ts_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) ts_q <= '0;
        else             ts_q <= ts_q + 32'd1;
    end

    assign push_entry = {ts_q, ch_s2};
`else
    assign push_entry = ch_s2;
`endif

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [LVL_W-1:0]   wr_cnt, rd_cnt, rd_next, lvl_after_pop;
    logic [ENTRY_W-1:0] head_q, head_next;
    logic               pop, full, push, drop, keep_head;

    assign fifo_level = wr_cnt - rd_cnt;
    assign full       = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign pop        = out_valid & out_ready;
    assign push       = tick & (~full | pop);
    assign drop       = tick & full & ~pop;

    // NOTE: storage is not reset; only pointers and the output register need a known state.
    always_ff @(posedge clk_clk) begin
        if (push) mem[wr_cnt[PTR_W-1:0]] <= push_entry;
    end

    // Head register is loaded with the entry that will be at the front after this cycle;
    // a push into an otherwise empty FIFO bypasses the memory.
    always_comb begin
        rd_next       = rd_cnt + LVL_W'(pop);
        lvl_after_pop = fifo_level - LVL_W'(pop);
        keep_head     = (lvl_after_pop != '0) || push;
        head_next     = mem[rd_next[PTR_W-1:0]];
        if (push && lvl_after_pop == '0) head_next = push_entry;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            head_q    <= '0;
            out_valid <= 1'b0;
        end else begin
            wr_cnt    <= wr_cnt + LVL_W'(push);
            rd_cnt    <= rd_next;
            out_valid <= keep_head;
            if (keep_head) head_q <= head_next;
        end
    end

    assign out_data = head_q[FRAME_W-1:0];
`ifdef DL_TIMESTAMP_EN
    assign out_timestamp = head_q[ENTRY_W-1 -: 32];
`endif

    // A clear coinciding with a drop leaves exactly that one drop recorded.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            ovf_flag <= 1'b0;
            ovf_cnt  <= '0;
        end else if (clr_ovf) begin
            ovf_flag <= drop;
            ovf_cnt  <= CNT_W'(drop);
        end else if (drop) begin
            ovf_flag <= 1'b1;
            if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dl_multi_capture.sv
// Self-checking bench for dl_multi_capture: directed table, corner sequences, and a randomized
// run compared every cycle against a queue-based frame model.
module tb_dl_multi_capture;

    localparam int CH_NUM     = 4;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 16;
    localparam int CNT_W      = 16;
    localparam int M_IDLE     = 0;
    localparam int M_ARMED    = 1;
    localparam int M_RUN      = 2;

    logic        clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [31:0] ch_data_in = '0;
    logic        trig_in = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        trig_en = 1'b0;
    logic [15:0] sample_div = '0;
    logic [15:0] frame_limit = '0;
    logic        clr_ovf = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  fifo_level;
    logic        busy;
    logic        ovf_flag;
    logic [15:0] ovf_cnt;
`ifdef DL_TIMESTAMP_EN
    logic [31:0] out_timestamp;
`endif

    dl_multi_capture #(
        .CH_NUM(CH_NUM), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W), .CNT_W(CNT_W)
    ) dut (
        .clk_clk(clk),
        .reset_reset(reset_reset),
        .ch_data_in(ch_data_in),
        .trig_in(trig_in),
        .start(start),
        .stop(stop),
        .trig_en(trig_en),
        .sample_div(sample_div),
        .frame_limit(frame_limit),
        .clr_ovf(clr_ovf),
        .out_data(out_data),
`ifdef DL_TIMESTAMP_EN
        .out_timestamp(out_timestamp),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fifo_level(fifo_level),
        .busy(busy),
        .ovf_flag(ovf_flag),
        .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frames as a queue, sampling as "every (sample_div+1)th RUN cycle".
    logic [31:0] m_q[$];
    int          m_mode = M_IDLE;
    int          m_age = 0;
    int          m_frames = 0;
    logic [31:0] m_ch_p[2] = '{32'h0, 32'h0};
    logic        m_tr_p[3] = '{1'b0, 1'b0, 1'b0};
    logic        m_ovf_flag = 1'b0;
    int          m_ovf_cnt = 0;

    task automatic model_step();
        bit          pop, full, tick, drop, tedge;
        logic [31:0] frame;
        if (reset_reset) begin
            m_q.delete();
            m_mode = M_IDLE;
            m_age = 0;
            m_frames = 0;
            m_ch_p = '{32'h0, 32'h0};
            m_tr_p = '{1'b0, 1'b0, 1'b0};
            m_ovf_flag = 1'b0;
            m_ovf_cnt = 0;
            return;
        end
        pop   = (m_q.size() > 0) && out_ready;
        full  = (m_q.size() == FIFO_DEPTH);
        frame = m_ch_p[1];
        tedge = m_tr_p[1] && !m_tr_p[2];
        tick  = 1'b0;
        drop  = 1'b0;
        if (m_mode == M_IDLE) begin
            if (start && !stop) begin
                m_mode = M_ARMED;
                m_frames = 0;
            end
        end else if (m_mode == M_ARMED) begin
            if (stop) m_mode = M_IDLE;
            else if (!trig_en || tedge) begin
                m_mode = M_RUN;
                m_age = 0;
            end
        end else begin
            if (stop) m_mode = M_IDLE;
            else begin
                tick = (m_age % (int'(sample_div) + 1)) == 0;
                m_age++;
                if (tick) begin
                    m_frames++;
                    if (frame_limit != 0 && (m_frames & 32'hFFFF) == int'(frame_limit)) m_mode = M_IDLE;
                end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (tick) begin
            if (!full || pop) m_q.push_back(frame);
            else drop = 1'b1;
        end
        if (clr_ovf) begin
            m_ovf_flag = drop;
            m_ovf_cnt = drop ? 1 : 0;
        end else if (drop) begin
            m_ovf_flag = 1'b1;
            if (m_ovf_cnt < 65535) m_ovf_cnt++;
        end
        m_ch_p[1] = m_ch_p[0];
        m_ch_p[0] = ch_data_in;
        m_tr_p[2] = m_tr_p[1];
        m_tr_p[1] = m_tr_p[0];
        m_tr_p[0] = trig_in;
    endtask

    task automatic compare_model();
        logic [55:0] act, exp;
        logic [31:0] exp_data;
        exp_data = (m_q.size() > 0) ? m_q[0] : 32'h0;
        exp = {m_q.size() > 0, 5'(m_q.size()), m_mode != M_IDLE, m_ovf_flag, 16'(m_ovf_cnt), exp_data};
        act = {out_valid, fifo_level, busy, ovf_flag, ovf_cnt, out_valid ? out_data : 32'h0};
        check("model {valid,level,busy,flag,cnt,data}", act, exp);
    endtask

    task automatic tick_clk();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick_clk();
        start = 1'b0;
    endtask

    typedef struct {
        logic [15:0] div;
        logic [15:0] limit;
        logic [31:0] ch;
        int          exp_frames;
        int          exp_gap;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int got, prev;
        logic [31:0] prev_ts;
        bool_dummy: begin end

        vecs[0] = '{div: 16'd3, limit: 16'd4, ch: 32'hA1B2C3D4, exp_frames: 4, exp_gap: 4};
        vecs[1] = '{div: 16'd0, limit: 16'd5, ch: 32'h12345678, exp_frames: 5, exp_gap: 1};
        vecs[2] = '{div: 16'd7, limit: 16'd2, ch: 32'hDEADBEEF, exp_frames: 2, exp_gap: 8};
        vecs[3] = '{div: 16'd1, limit: 16'd1, ch: 32'h0F0F00FF, exp_frames: 1, exp_gap: 2};

        repeat (2) tick_clk();
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_data", out_data, 32'h0);
        check("reset fifo_level", fifo_level, 5'd0);
        check("reset busy", busy, 1'b0);
        check("reset ovf_flag", ovf_flag, 1'b0);
        check("reset ovf_cnt", ovf_cnt, 16'd0);
        reset_reset = 1'b0;

        // Table: capture bursts drained with out_ready held high.
        foreach (vecs[k]) begin
            trig_en = 1'b0;
            out_ready = 1'b1;
            sample_div = vecs[k].div;
            frame_limit = vecs[k].limit;
            ch_data_in = vecs[k].ch;
            repeat (3) tick_clk();
            pulse_start();
            check($sformatf("vec%0d busy after start", k), busy, 1'b1);
            got = 0;
            prev = -1;
            prev_ts = '0;
            for (int cyc = 0; cyc < 200; cyc++) begin
                tick_clk();
                if (out_valid) begin
                    check($sformatf("vec%0d frame data", k), out_data, vecs[k].ch);
                    if (prev >= 0) check($sformatf("vec%0d tick spacing", k), cyc - prev, vecs[k].exp_gap);
`ifdef DL_TIMESTAMP_EN
                    if (prev >= 0) check($sformatf("vec%0d timestamp delta", k), out_timestamp - prev_ts,
                                         32'(vecs[k].exp_gap));
                    prev_ts = out_timestamp;
`endif
                    prev = cyc;
                    got++;
                end
                if (!busy && !out_valid) break;
            end
            check($sformatf("vec%0d frame count", k), got, vecs[k].exp_frames);
            check($sformatf("vec%0d back to idle", k), busy, 1'b0);
        end

        // Trigger wait: nothing captured until a trig_in rising edge crosses the synchronizer.
        out_ready = 1'b0;
        trig_en = 1'b1;
        sample_div = 16'd3;
        frame_limit = 16'd1;
        ch_data_in = 32'h600DF00D;
        repeat (3) tick_clk();
        pulse_start();
        repeat (20) tick_clk();
        check("trig wait no frame", out_valid, 1'b0);
        check("trig wait level", fifo_level, 5'd0);
        check("trig wait busy", busy, 1'b1);
        trig_in = 1'b1;
        repeat (3) tick_clk();
        check("trig +3 not yet valid", out_valid, 1'b0);
        tick_clk();
        check("trig +4 valid", out_valid, 1'b1);
        check("trig frame data", out_data, 32'h600DF00D);
        check("trig limit reached idle", busy, 1'b0);
        out_ready = 1'b1;
        tick_clk();
        check("trig drained", fifo_level, 5'd0);

        // Overflow: 20 back-to-back frames into a 16-deep FIFO with no consumer.
        out_ready = 1'b0;
        trig_en = 1'b0;
        trig_in = 1'b0;
        sample_div = 16'd0;
        frame_limit = 16'd20;
        ch_data_in = 32'hC0FFEE00;
        pulse_start();
        for (int i = 0; i < 25; i++) begin
            ch_data_in = 32'h1000_0000 + i;
            tick_clk();
        end
        check("ovf level full", fifo_level, 5'd16);
        check("ovf flag set", ovf_flag, 1'b1);
        check("ovf count", ovf_cnt, 16'd4);
        check("ovf head is frame 0", out_data, 32'hC0FFEE00);
        check("ovf idle after limit", busy, 1'b0);
        clr_ovf = 1'b1;
        tick_clk();
        clr_ovf = 1'b0;
        check("clr_ovf count", ovf_cnt, 16'd0);
        check("clr_ovf flag", ovf_flag, 1'b0);
        check("clr_ovf keeps frames", fifo_level, 5'd16);

        // Full FIFO with simultaneous pop: every tick accepted, no overflow.
        frame_limit = 16'd0;
        pulse_start();
        tick_clk();
        out_ready = 1'b1;
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 10; i++) begin
                tick_clk();
                if (fifo_level != 5'd16) bad++;
            end
            check("full+pop cycles with level != 16", bad, 0);
        end
        check("full+pop no overflow", ovf_cnt, 16'd0);
        stop = 1'b1;
        tick_clk();
        stop = 1'b0;
        check("stop -> idle", busy, 1'b0);
        check("stop cycle pops only", fifo_level, 5'd15);
        for (int i = 0; i < 30 && fifo_level != 0; i++) tick_clk();
        check("drain in idle", fifo_level, 5'd0);
        check("drain ovf unchanged", ovf_cnt, 16'd0);

        // stop coinciding with the first RUN tick wins: no frame.
        pulse_start();
        tick_clk();
        stop = 1'b1;
        tick_clk();
        stop = 1'b0;
        check("stop@first tick level", fifo_level, 5'd0);
        check("stop@first tick busy", busy, 1'b0);
        tick_clk();
        check("stop@first tick no valid", out_valid, 1'b0);

        // Reset mid-RUN flushes the FIFO.
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 20 && fifo_level != 5'd5; i++) tick_clk();
        check("mid-run level reached 5", fifo_level, 5'd5);
        reset_reset = 1'b1;
        tick_clk();
        check("reset flush valid", out_valid, 1'b0);
        check("reset flush level", fifo_level, 5'd0);
        check("reset flush busy", busy, 1'b0);
        reset_reset = 1'b0;

        // Randomized segments; configuration only changes across a reset.
        for (int seg = 0; seg < 6; seg++) begin
            reset_reset = 1'b1;
            start = 1'b0;
            stop = 1'b0;
            clr_ovf = 1'b0;
            sample_div = 16'($urandom_range(0, 3));
            frame_limit = 16'($urandom_range(0, 6));
            trig_en = 1'($urandom_range(0, 1));
            tick_clk();
            reset_reset = 1'b0;
            for (int c = 0; c < 500; c++) begin
                start = ($urandom_range(0, 9) == 0);
                stop = ($urandom_range(0, 39) == 0);
                out_ready = ($urandom_range(0, 9) < 6);
                clr_ovf = ($urandom_range(0, 49) == 0);
                ch_data_in = $urandom;
                if ($urandom_range(0, 5) == 0) trig_in = ~trig_in;
                tick_clk();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
